// File: rtl/reaction_timer.sv
// Reaction-time core: random pre-stimulus delay, then a 4-digit BCD millisecond count until Stop.
// Optional false-start detection (Stop during WAIT) is built when FALSE_START_EN is defined.
module reaction_timer #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    output logic       Stim,
    output logic [3:0] BCD3,
    output logic [3:0] BCD2,
    output logic [3:0] BCD1,
    output logic [3:0] BCD0,
    output logic       Done,
    output logic       FalseStart,
    output logic [2:0] dbg_state_o
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [13:0]     MIN_DLY   = 14'(MIN_DELAY_MS);
    localparam logic [15:0]     BCD_MAX   = 16'h9999;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RUN   = 3'd2,
`ifdef FALSE_START_EN
        ST_FAULT = 3'd4,
`endif
        ST_DONE  = 3'd3
    } state_t;

    state_t        state_q;
    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_d;
    logic [PW-1:0] presc_q;
    logic [13:0]   wait_q;
    logic [13:0]   wait_load;
    logic [15:0]   bcd_q;
    logic [15:0]   bcd_d;
    logic          inc_carry;
    logic          stim_q;
    logic          done_q;
    logic          tick;
`ifdef FALSE_START_EN
    logic          fs_q;
`endif

    // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form)
    assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign tick      = (presc_q == PRESC_MAX);
    assign wait_load = MIN_DLY + {3'b000, lfsr_q[10:0]};

    // Decimal increment with ripple carry across the four digits
    always_comb begin
        bcd_d     = bcd_q;
        inc_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (inc_carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_d[4*i +: 4] = 4'd0;
                end else begin
                    bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    inc_carry       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= 16'hACE1;
            presc_q <= '0;
            wait_q  <= '0;
            bcd_q   <= '0;
            stim_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FALSE_START_EN
            fs_q    <= 1'b0;
`endif
        end else begin
            lfsr_q  <= lfsr_d;
            presc_q <= tick ? '0 : presc_q + 1'b1;
            case (state_q)
                ST_IDLE,
`ifdef FALSE_START_EN
                ST_FAULT,
`endif
                ST_DONE: begin
                    if (Start) begin
                        state_q <= ST_WAIT;
                        wait_q  <= wait_load;
                        presc_q <= '0;
                        bcd_q   <= '0;
                        done_q  <= 1'b0;
`ifdef FALSE_START_EN
                        fs_q    <= 1'b0;
`endif
                    end
                end
                ST_WAIT: begin
`ifdef FALSE_START_EN
                    // A premature press outranks the final delay tick
                    if (Stop) begin
                        state_q <= ST_FAULT;
                        fs_q    <= 1'b1;
                        bcd_q   <= '0;
                    end else
`endif
                    if (tick) begin
                        wait_q <= wait_q - 14'd1;
                        if (wait_q == 14'd1) begin
                            state_q <= ST_RUN;
                            presc_q <= '0;
                            bcd_q   <= '0;
                            stim_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Stop wins over a coincident tick, so that tick is not counted
                    if (Stop) begin
                        state_q <= ST_DONE;
                        stim_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tick) begin
                        bcd_q <= bcd_d;
                        if (bcd_d == BCD_MAX) begin
                            state_q <= ST_DONE;
                            stim_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Stim        = stim_q;
    assign BCD3        = bcd_q[15:12];
    assign BCD2        = bcd_q[11:8];
    assign BCD1        = bcd_q[7:4];
    assign BCD0        = bcd_q[3:0];
    assign Done        = done_q;
    assign dbg_state_o = state_q;
`ifdef FALSE_START_EN
    assign FalseStart  = fs_q;
`else
    assign FalseStart  = 1'b0;
`endif

endmodule
